// File: rtl/gates_n_pkg.sv
// Shared encodings for the gates_n logic unit: function selects, packet modes and FSM states.
package gates_n_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_ORN  = 3'd7
    } op_e;

    typedef enum logic {
        MODE_PAIR = 1'b0,
        MODE_FOLD = 1'b1
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FOLD = 1'b1
    } state_e;

endpackage

// File: rtl/gates_n_op.sv
// Combinational two-operand bitwise function f(x,y) selected by op.
module gates_n_op
    import gates_n_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  op_e              op,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        f = '0;
        case (op)
            OP_AND:  f = x & y;
            OP_NAND: f = ~(x & y);
            OP_OR:   f = x | y;
            OP_NOR:  f = ~(x | y);
            OP_XOR:  f = x ^ y;
            OP_XNOR: f = ~(x ^ y);
            OP_ANDN: f = x & ~y;
            OP_ORN:  f = x | ~y;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/gates_n.sv
// Registered streaming bitwise logic unit with per-beat PAIR mode and packet FOLD reduction.
// Optional zero/all-ones result flags are enabled by defining GATES_N_FLAGS_EN.
module gates_n
    import gates_n_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  MAX_BEATS = 16,
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_beats,
`ifdef GATES_N_FLAGS_EN
    output logic             out_zero,
    output logic             out_ones,
`endif
    output logic             out_ovf
);

    state_e           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    cnt_reg;
    logic             ovf_sticky_reg;
    op_e              fold_op_reg;

    logic [WIDTH-1:0] pair_f;
    logic [WIDTH-1:0] fold_f;
    logic             accept;
    logic             at_max;
    logic [CW-1:0]    cnt_next;

    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [CW-1:0]    load_beats;
    logic             load_ovf;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign at_max   = (cnt_reg == CW'(MAX_BEATS));
    assign cnt_next = at_max ? cnt_reg : cnt_reg + CW'(1);

    gates_n_op #(.WIDTH(WIDTH)) u_pair_op (
        .x  (in_a),
        .y  (in_b),
        .op (op_e'(in_op)),
        .f  (pair_f)
    );

    gates_n_op #(.WIDTH(WIDTH)) u_fold_op (
        .x  (acc_reg),
        .y  (in_a),
        .op (fold_op_reg),
        .f  (fold_f)
    );

    // Only a PAIR beat or the closing FOLD beat ever writes the output register.
    always_comb begin
        load       = 1'b0;
        load_data  = '0;
        load_beats = '0;
        load_ovf   = 1'b0;
        if (accept) begin
            if (state_reg == S_FOLD) begin
                if (in_last) begin
                    load       = 1'b1;
                    load_data  = fold_f;
                    load_beats = cnt_next;
                    load_ovf   = ovf_sticky_reg | at_max;
                end
            end else if (mode_e'(in_mode) == MODE_PAIR) begin
                load       = 1'b1;
                load_data  = pair_f;
                load_beats = CW'(1);
            end else if (in_last) begin
                load       = 1'b1;
                load_data  = in_a;
                load_beats = CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            ovf_sticky_reg <= 1'b0;
            fold_op_reg    <= OP_AND;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_beats      <= '0;
            out_ovf        <= 1'b0;
`ifdef GATES_N_FLAGS_EN
            out_zero       <= 1'b0;
            out_ones       <= 1'b0;
`endif
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_beats <= load_beats;
                out_ovf   <= load_ovf;
`ifdef GATES_N_FLAGS_EN
                out_zero  <= (load_data == '0);
                out_ones  <= (load_data == '1);
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                if (state_reg == S_IDLE) begin
                    if (mode_e'(in_mode) == MODE_FOLD && !in_last) begin
                        acc_reg     <= in_a;
                        cnt_reg     <= CW'(1);
                        fold_op_reg <= op_e'(in_op);
                        state_reg   <= S_FOLD;
                    end
                end else if (in_last) begin
                    state_reg      <= S_IDLE;
                    acc_reg        <= '0;
                    cnt_reg        <= '0;
                    ovf_sticky_reg <= 1'b0;
                end else begin
                    // Counting saturates but folding carries on past MAX_BEATS.
                    acc_reg <= fold_f;
                    cnt_reg <= cnt_next;
                    if (at_max) begin
                        ovf_sticky_reg <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
